// File: rtl/sprite_frame_controller_if.sv
// rtl/sprite_frame_controller_if.sv - control/strobe bundle between controller, user inputs and datapath
interface sprite_frame_controller_if;
    logic       go;
    logic       pause;
    logic       done;
    logic       timer;
    logic       cnA;
    logic       cnB;
    logic       cnC;
    logic       cnD;
    logic       Enable;
    logic       plot;
    logic       busy;
    logic [2:0] state_o;

    modport master (
        input  go, pause, done, timer,
        output cnA, cnB, cnC, cnD, Enable, plot, busy, state_o
    );

    modport slave (
        output go, pause, done, timer,
        input  cnA, cnB, cnC, cnD, Enable, plot, busy, state_o
    );
endinterface

// File: rtl/sprite_frame_controller.sv
// rtl/sprite_frame_controller.sv - draw/wait/erase/update sequencer with frame timer and plot enable
module sprite_frame_controller #(
    parameter int FRAME_CYCLES    = 833334,
    parameter int FRAMES_PER_MOVE = 4,
    parameter int CW              = 20
) (
    input  logic                       clk,
    input  logic                       reset,
    sprite_frame_controller_if.master  bus
);
    localparam int FTW = (FRAMES_PER_MOVE > 1) ? $clog2(FRAMES_PER_MOVE) : 1;
    localparam logic [CW-1:0]  FC_LAST = CW'(FRAME_CYCLES - 1);
    localparam logic [FTW-1:0] FT_LAST = FTW'(FRAMES_PER_MOVE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRAW   = 3'd1,
        S_WAIT   = 3'd3,
        S_ERASE  = 3'd4,
        S_UPDATE = 3'd6
    } state_e;

    // Held as raw bits so the unused codes 2/5/7 stay representable and recoverable.
    logic [2:0]     state_q, state_d;
    logic [CW-1:0]  fc_q, fc_d;
    logic [FTW-1:0] ft_q, ft_d;
    logic           enable_q, enable_d;
    logic           plot_q, plot_d;
    logic           count_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            fc_q     <= '0;
            ft_q     <= '0;
            enable_q <= 1'b0;
            plot_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            fc_q     <= fc_d;
            ft_q     <= ft_d;
            enable_q <= enable_d;
            plot_q   <= plot_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        fc_d     = fc_q;
        ft_d     = ft_q;
        enable_d = 1'b0;
        // The Enable cycle itself does not count; WAIT leaves on the following edge.
        count_en = (state_q == S_WAIT) && bus.timer && !bus.pause && !enable_q;
        plot_d   = ((state_q == S_DRAW) || (state_q == S_ERASE)) && !bus.done;

        case (state_q)
            S_IDLE:   if (bus.go)   state_d = S_DRAW;
            S_DRAW:   if (bus.done) state_d = S_WAIT;
            S_WAIT:   if (enable_q) state_d = S_ERASE;
            S_ERASE:  if (bus.done) state_d = S_UPDATE;
            S_UPDATE: state_d = bus.go ? S_DRAW : S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (state_q != S_WAIT) begin
            fc_d = '0;
            ft_d = '0;
        end else if (count_en) begin
            if (fc_q == FC_LAST) begin
                fc_d = '0;
                if (ft_q == FT_LAST) begin
                    enable_d = 1'b1;
                end else begin
                    ft_d = ft_q + 1'b1;
                end
            end else begin
                fc_d = fc_q + 1'b1;
            end
        end
    end

    assign bus.cnA     = (state_q == S_DRAW);
    assign bus.cnB     = (state_q == S_WAIT);
    assign bus.cnC     = (state_q == S_ERASE);
    assign bus.cnD     = (state_q == S_UPDATE);
    assign bus.Enable  = enable_q;
    assign bus.plot    = plot_q;
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.state_o = state_q;
endmodule

// File: doc/sprite_frame_controller.md
Name: sprite_frame_controller

Overview:
- Control FSM that sequences the sprite-drawing datapath through four phases: draw, frame wait, erase, position update.
- Drives the datapath's one-hot phase strobes `cnA`–`cnD`, owns the frame-delay timer, and generates the VGA write enable.
- Sits between top-level user inputs (`go`, `pause`) and the datapath / VGA adapter.

Parameters:
- FRAME_CYCLES, 833334, clk cycles per video frame (50 MHz / 60 Hz).
- FRAMES_PER_MOVE, 4, frames waited between draw and erase.
- CW, 20, frame-cycle counter width; must satisfy 2^CW > FRAME_CYCLES-1.

Ports:
- clk  in  1  system clock, all logic posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- go  in  1  level; run animation loop while high.
- pause  in  1  level; freezes frame timer in WAIT.
- done  in  1  datapath: current draw/erase sweep complete (registered).
- timer  in  1  datapath: frame timer requested (high while datapath in wait phase).
- cnA  out  1  draw phase strobe.
- cnB  out  1  wait phase strobe.
- cnC  out  1  erase phase strobe.
- cnD  out  1  update phase strobe.
- Enable  out  1  one-cycle pulse: frame wait finished.
- plot  out  1  VGA write enable.
- busy  out  1  high in any state except IDLE.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- States and encodings: IDLE=0, DRAW=1, WAIT=3, ERASE=4, UPDATE=6. Encodings 2, 5 and 7 are illegal and decode to IDLE on the next clock.
- Outputs are Moore-decoded from the state register; exactly one of `cnA`–`cnD` is high outside IDLE. All are 0 in IDLE.
- IDLE: if `go`=1, next state is DRAW.
- DRAW: `cnA`=1. When `done`=1, next state is WAIT.
- WAIT: `cnB`=1.
  - The frame counter `fc` (CW bits) and frame tally `ft` advance only when `timer`=1 and `pause`=0.
  - `fc` counts 0..FRAME_CYCLES-1, then wraps to 0 and increments `ft`.
  - When `ft` reaches FRAMES_PER_MOVE-1 and `fc` wraps, `Enable` pulses for exactly 1 cycle and the next state is ERASE.
  - `fc` and `ft` clear on entry to WAIT.
  - While `timer`=0 in WAIT (datapath not yet acknowledged), the counters hold.
- ERASE: `cnC`=1. When `done`=1, next state is UPDATE.
- UPDATE: `cnD`=1 for exactly 1 cycle. Next state is DRAW if `go`=1, otherwise IDLE.
- `plot` timing:
  - Registered copy of (state==DRAW or ERASE) AND NOT `done`, i.e. delayed 1 cycle to align with the datapath's registered coordinates.
  - Forced to 0 the cycle after `done` is seen.
- Simultaneous events:
  - `done`=1 on the first DRAW cycle is honoured: DRAW is 1 cycle long.
  - `pause` and the final wrap in the same cycle: `pause` wins; no `Enable`, and the counter holds.
- `go` deasserted mid-loop: the current loop completes through UPDATE, then the block goes to IDLE. The sprite is left erased and updated.
- Reset (asynchronous, any time): state=IDLE, `fc`=0, `ft`=0, `plot`=0, `Enable`=0, `cnA`–`cnD`=0, `busy`=0, `state_o`=0. Release of reset takes effect on the next clk edge.

Test Plan (FRAME_CYCLES=4, FRAMES_PER_MOVE=2 unless noted):
- Reset, then `go`=1 with a datapath model whose `done` rises 300 cycles after `cnA` -> `cnA` high 300 cycles, `plot` high 299 cycles (1-cycle lag), then `cnB`=1 and `state_o`=3.
- WAIT with `timer`=1 and `pause`=0 -> `Enable` pulses exactly 8 cycles after `timer` rises; ERASE is entered the next cycle.
- WAIT with `pause`=1 for 5 cycles mid-count -> `Enable` delayed by exactly 5 cycles; `fc` frozen during the pause.
- Full loop with `go` dropped during ERASE -> `cnD` high 1 cycle, then `state_o`=0, `busy`=0, all strobes 0.
- Assert `reset` asynchronously mid-DRAW (between clock edges) -> all outputs 0 immediately, without waiting for a clk edge; after release with `go`=1, DRAW is re-entered.
- Force state register to 5 via bench -> next clock `state_o`=0 and no strobe is asserted.
